// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low a..g pattern table and capture FSM states.
// The hex->7-segment driver uses the same table, so encode and decode cannot drift apart.
package seg7_pkg;

    // seg[0] = a ... seg[6] = g, active-low
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_PAT [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StHold
    } cap_state_e;

endpackage

// File: rtl/seg7_hex_capture_if.sv
// Display bus plus recovered-value outputs of the 7-segment capture block.
interface seg7_hex_capture_if #(
    parameter int unsigned DIGITS = 4
);
    logic [0:6]          seg_n;
    logic [DIGITS-1:0]   dig_en_n;
    logic                clear;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_ok;
    logic                frame_valid;
    logic                err;

    modport master (
        output seg_n, dig_en_n, clear,
        input  value, digit_ok, frame_valid, err
    );

    modport slave (
        input  seg_n, dig_en_n, clear,
        output value, digit_ok, frame_valid, err
    );
endinterface

// File: rtl/seg7_pattern_to_hex.sv
// Combinational inverse of the hex->7-segment table: pattern to nibble, legality and blank flags.
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  seg_t       seg_n,
    output logic [3:0] nibble,
    output logic       ok,
    output logic       blank
);
    always_comb begin
        nibble = 4'h0;
        ok     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_PAT[i]) begin
                nibble = 4'(i);
                ok     = 1'b1;
            end
        end
        blank = (seg_n == SEG_BLANK);
    end
endmodule

// File: rtl/seg7_hex_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and publishes
// a complete DIGITS-wide value once every digit has been seen stable.
module seg7_hex_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    seg7_hex_capture_if.slave  bus
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    seg_t              seg_q, prev_seg_q;
    logic [DIGITS-1:0] en_q, prev_en_q;
    cap_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0] shadow_ok_q, shadow_ok_d;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0] digit_ok_q;
    logic              frame_valid_q, err_q;

    logic [IdxW-1:0]   idx;
    int unsigned       n_low;
    logic              valid, same, capture, commit;
    logic [3:0]        nibble;
    logic              pat_ok, pat_blank;

    seg7_pattern_to_hex u_decode (
        .seg_n  (seg_q),
        .nibble (nibble),
        .ok     (pat_ok),
        .blank  (pat_blank)
    );

    always_comb begin
        n_low = 0;
        idx   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!en_q[i]) begin
                n_low = n_low + 1;
                idx   = IdxW'(i);
            end
        end
        valid = (n_low == 1);
        same  = (seg_q == prev_seg_q) && (en_q == prev_en_q);
    end

    // Stability tracker: capture fires once, on the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (bus.clear || !valid) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StTrack;
                    cnt_d   = CntW'(1);
                end
                StTrack: begin
                    if (!same) begin
                        cnt_d = CntW'(1);
                    end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
                        state_d = StHold;
                        cnt_d   = CntW'(STABLE_CYCLES);
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (!same) begin
                        state_d = StTrack;
                        cnt_d   = CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Commit reads the old shadow; a same-cycle capture lands in the freshly cleared mask.
    always_comb begin
        commit      = (&mask_q) && !bus.clear;
        mask_d      = commit ? '0 : mask_q;
        shadow_d    = shadow_q;
        shadow_ok_d = shadow_ok_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (capture && (idx == IdxW'(i))) begin
                mask_d[i]          = 1'b1;
                shadow_d[4*i +: 4] = nibble;
                shadow_ok_d[i]     = pat_ok;
            end
        end
        if (bus.clear) mask_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= SEG_BLANK;
            prev_seg_q    <= SEG_BLANK;
            en_q          <= '1;
            prev_en_q     <= '1;
            state_q       <= StIdle;
            cnt_q         <= '0;
            mask_q        <= '0;
            shadow_q      <= '0;
            shadow_ok_q   <= '0;
            value_q       <= '0;
            digit_ok_q    <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            seg_q         <= bus.seg_n;
            en_q          <= bus.dig_en_n;
            prev_seg_q    <= seg_q;
            prev_en_q     <= en_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            shadow_ok_q   <= shadow_ok_d;
            frame_valid_q <= commit;
            err_q         <= capture && !pat_ok && !pat_blank;
            if (commit) begin
                value_q    <= shadow_q;
                digit_ok_q <= shadow_ok_q;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_ok    = digit_ok_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seg7_hex_capture.sv
// Directed and random stimulus for seg7_hex_capture, checked against a run-length reference model.
module tb_seg7_hex_capture;
    localparam int D = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_hex_capture_if #(.DIGITS(D)) bus ();

    seg7_hex_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int fv_count = 0;
    int err_count = 0;

    // Reference model state: last two samples seen by the DUT, run length, frame contents.
    logic [6:0] d1_seg, d2_seg;
    logic [3:0] d1_en, d2_en;
    int         run;
    logic [3:0] m_shadow [4];
    bit         m_ok [4];
    bit         m_mask [4];
    logic [15:0] m_value;
    logic [3:0] m_dok;
    bit         m_fv, m_err;

    function automatic logic [6:0] pat_of(int h);
        case (h)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;  10: return 7'b0001000; 11: return 7'b1100000;
            12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic int low_count(logic [3:0] en);
        int n = 0;
        for (int i = 0; i < D; i++) if (!en[i]) n++;
        return n;
    endfunction

    function automatic int low_index(logic [3:0] en);
        int k = 0;
        for (int i = 0; i < D; i++) if (!en[i]) k = i;
        return k;
    endfunction

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] nib, output bit ok,
                              output bit illegal);
        nib = 4'h0;
        ok = 1'b0;
        illegal = (s != 7'b1111111);
        for (int h = 0; h < 16; h++) begin
            if (s == pat_of(h)) begin
                nib = 4'(h);
                ok = 1'b1;
                illegal = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        d1_seg = 7'h7F; d2_seg = 7'h7F; d1_en = 4'hF; d2_en = 4'hF;
        run = 0;
        for (int i = 0; i < D; i++) begin
            m_shadow[i] = 4'h0; m_ok[i] = 1'b0; m_mask[i] = 1'b0;
        end
        m_value = 16'h0; m_dok = 4'h0; m_fv = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [6:0] in_seg, input logic [3:0] in_en, input bit clr);
        bit full, valid, same, cap, ok, illegal;
        logic [3:0] nib;
        int dg;
        full = 1'b1;
        for (int i = 0; i < D; i++) if (!m_mask[i]) full = 1'b0;
        m_fv = full && !clr;
        if (m_fv) begin
            for (int i = 0; i < D; i++) begin
                m_value[4*i +: 4] = m_shadow[i];
                m_dok[i] = m_ok[i];
                m_mask[i] = 1'b0;
            end
        end
        valid = (low_count(d1_en) == 1);
        same = (d1_seg == d2_seg) && (d1_en == d2_en);
        if (clr || !valid) run = 0;
        else if (run > 0 && same) run = (run > S) ? run : run + 1;
        else run = 1;
        cap = !clr && valid && (run == S);
        m_err = 1'b0;
        if (cap) begin
            ref_decode(d1_seg, nib, ok, illegal);
            dg = low_index(d1_en);
            m_shadow[dg] = nib;
            m_ok[dg] = ok;
            m_mask[dg] = 1'b1;
            m_err = illegal;
        end
        if (clr) for (int i = 0; i < D; i++) m_mask[i] = 1'b0;
        d2_seg = d1_seg; d2_en = d1_en;
        d1_seg = in_seg; d1_en = in_en;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [6:0] seg, input logic [3:0] en, input bit clr);
        bus.seg_n = seg;
        bus.dig_en_n = en;
        bus.clear = clr;
        @(posedge clk);
        model_edge(seg, en, clr);
        #1;
        check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        check("err", 32'(bus.err), 32'(m_err));
        check("value", 32'(bus.value), 32'(m_value));
        check("digit_ok", 32'(bus.digit_ok), 32'(m_dok));
        if (bus.frame_valid === 1'b1) fv_count++;
        if (bus.err === 1'b1) err_count++;
    endtask

    task automatic hold(input logic [6:0] seg, input int dg, input int n);
        logic [3:0] en;
        en = ~(4'b0001 << dg);
        repeat (n) step(seg, en, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(7'h7F, 4'hF, 1'b0);
    endtask

    initial begin
        logic [6:0] rseg;
        logic [3:0] ren;
        int sel, n;
        bus.seg_n = 7'h7F;
        bus.dig_en_n = 4'hF;
        bus.clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(bus.value), 32'h0);
        check("reset_digit_ok", 32'(bus.digit_ok), 32'h0);
        check("reset_fv", 32'(bus.frame_valid), 32'h0);
        check("reset_err", 32'(bus.err), 32'h0);
        rst_n = 1'b1;

        idle(10);
        check("no_frame_idle", 32'(fv_count), 32'd0);

        // Basic scan: digit0=4 .. digit3=1
        fv_count = 0; err_count = 0;
        hold(pat_of(4), 0, 8); hold(pat_of(3), 1, 8);
        hold(pat_of(2), 2, 8); hold(pat_of(1), 3, 8);
        idle(3);
        check("scan_frames", 32'(fv_count), 32'd1);
        check("scan_value", 32'(bus.value), 32'h1234);
        check("scan_ok", 32'(bus.digit_ok), 32'hF);
        check("scan_err", 32'(err_count), 32'd0);

        // Reset mid-frame: outputs drop at once, partial mask is discarded
        hold(pat_of(5), 0, 8); hold(pat_of(6), 1, 8);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_value", 32'(bus.value), 32'h0);
        check("async_rst_ok", 32'(bus.digit_ok), 32'h0);
        check("async_rst_fv", 32'(bus.frame_valid), 32'h0);
        check("async_rst_err", 32'(bus.err), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        fv_count = 0;
        hold(pat_of(10), 2, 8); hold(pat_of(11), 3, 8);
        idle(3);
        check("post_rst_no_frame", 32'(fv_count), 32'd0);
        hold(pat_of(12), 0, 8); hold(pat_of(13), 1, 8);
        idle(3);
        check("post_rst_frames", 32'(fv_count), 32'd1);
        check("post_rst_value", 32'(bus.value), 32'hBADC);

        // Glitch shorter than the stability window is ignored
        fv_count = 0; err_count = 0;
        hold(pat_of(0), 0, 8);
        hold(7'b0000110, 1, 3); hold(7'b0010010, 1, 6);
        hold(pat_of(5), 2, 8); hold(pat_of(6), 3, 8);
        idle(3);
        check("glitch_frames", 32'(fv_count), 32'd1);
        check("glitch_value", 32'(bus.value), 32'h6520);
        check("glitch_err", 32'(err_count), 32'd0);

        // Illegal pattern on digit 2
        fv_count = 0; err_count = 0;
        hold(pat_of(8), 0, 8); hold(pat_of(9), 1, 8);
        hold(7'b1111110, 2, 5); hold(pat_of(7), 3, 8);
        idle(3);
        check("illegal_err", 32'(err_count), 32'd1);
        check("illegal_frames", 32'(fv_count), 32'd1);
        check("illegal_value", 32'(bus.value), 32'h7098);
        check("illegal_ok", 32'(bus.digit_ok), 32'b1011);

        // Two enables low: ignored, partial mask survives
        fv_count = 0;
        hold(pat_of(1), 0, 8); hold(pat_of(2), 1, 8);
        repeat (10) step(pat_of(8), 4'b1100, 1'b0);
        check("bad_en_no_frame", 32'(fv_count), 32'd0);
        check("bad_en_value_held", 32'(bus.value), 32'h7098);
        hold(pat_of(3), 2, 8); hold(pat_of(4), 3, 8);
        idle(3);
        check("bad_en_frames", 32'(fv_count), 32'd1);
        check("bad_en_value", 32'(bus.value), 32'h4321);

        // Clear mid-frame, then rescan in reverse digit order
        fv_count = 0;
        hold(pat_of(14), 0, 8); hold(pat_of(15), 1, 8);
        step(7'h7F, 4'hF, 1'b1);
        hold(pat_of(5), 3, 8); hold(pat_of(3), 2, 8);
        hold(pat_of(2), 1, 8); hold(pat_of(1), 0, 8);
        idle(3);
        check("clear_frames", 32'(fv_count), 32'd1);
        check("clear_value", 32'(bus.value), 32'h5321);
        check("clear_ok", 32'(bus.digit_ok), 32'hF);

        // Random segments: model checks every cycle
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) rseg = pat_of($urandom_range(0, 15));
            else if (sel == 7) rseg = 7'h7F;
            else rseg = 7'($urandom);
            if ($urandom_range(0, 9) < 8) ren = ~(4'b0001 << $urandom_range(0, 3));
            else ren = 4'($urandom);
            n = $urandom_range(1, 8);
            repeat (n) step(rseg, ren, ($urandom_range(0, 39) == 0));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
